tag_tree_sink: RTL

Root-side consumer of the tag arbitration tree. Accepts the winning core tag from the root tree node through its rdy/ack handshake, and prefetches claimed tags into a small show-ahead FIFO. Presents them to the packet dispatcher on a valid/ready interface, so a free core's tag is available with zero wait when a packet arrives. Each accepted tag is a core already claimed by the tree; the sink never drops or duplicates one.

---
 rtl/tag_tree_sink_pkg.sv | 12 +
 rtl/tag_tree_sink_fifo.sv | 61 ++++++
 rtl/tag_tree_sink.sv | 55 +++++
 3 files changed

// File: rtl/tag_tree_sink_pkg.sv
// Shared constants and helpers for the tag tree root sink and its FIFO.
package tag_tree_sink_pkg;

    localparam int unsigned TAG_SZ_DEFAULT = 5;
    localparam int unsigned DEPTH_DEFAULT  = 4;

    // True while the FIFO can take one more entry.
    function automatic logic has_room(input int unsigned cnt, input int unsigned depth);
        return cnt < depth;
    endfunction

endpackage

// File: rtl/tag_tree_sink_fifo.sv
// Show-ahead FIFO holding claimed tags: storage, wrapping pointers and occupancy.
module tag_tree_sink_fifo
    import tag_tree_sink_pkg::*;
#(
    parameter int unsigned TAG_SZ = TAG_SZ_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [TAG_SZ-1:0]        push_tag,
    input  logic                     pop,
    output logic [TAG_SZ-1:0]        head_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [TAG_SZ-1:0] mem_q [DEPTH];
    logic [TAG_SZ-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    // Next-state: pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; only pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_tag = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/tag_tree_sink.sv
// Root-side consumer of the tag arbitration tree: rdy/ack in, show-ahead valid/ready out.
module tag_tree_sink
    import tag_tree_sink_pkg::*;
#(
    parameter int unsigned TAG_SZ = TAG_SZ_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TAG_SZ-1:0]        tag,
    input  logic                     rdy,
    output logic                     ack,
    output logic [TAG_SZ-1:0]        out_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          push_c;
    logic          pop_c;
    logic [CW-1:0] count_w;

    // Ack depends only on rdy and the registered count, never on out_ready,
    // so a same-cycle pop cannot unblock a full FIFO.
    always_comb begin
        push_c = 1'b0;
        pop_c  = 1'b0;
        if (!rst && rdy && has_room(32'(count_w), DEPTH)) begin
            push_c = 1'b1;
        end
        if ((count_w != '0) && out_ready) begin
            pop_c = 1'b1;
        end
    end

    tag_tree_sink_fifo #(
        .TAG_SZ (TAG_SZ),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_c),
        .push_tag (tag),
        .pop      (pop_c),
        .head_tag (out_tag),
        .count    (count_w)
    );

    assign ack       = push_c;
    assign out_valid = (count_w != '0);
    assign count     = count_w;

endmodule
